// File: rtl/object_spawn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : object_spawn_sequencer_if
// Description : Bus bundle between the object spawn sequencer, its pattern
//               ROM and the collider consumer (descriptor handoff + status).
// Revision    : 1.0 - initial release
// ============================================================================
interface object_spawn_sequencer_if #(
   parameter int ADDR_WIDTH = 8
);
   // control / timing inputs
   logic                  clk_centi_second;
   logic                  start;
   logic                  pause;
   // pattern ROM port
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [66:0]           rom_data;
   // descriptor bus
   logic [2:0]            object_movement_direction;
   logic [9:0]            object_pos_x;
   logic [9:0]            object_pos_y;
   logic [9:0]            object_w;
   logic [9:0]            object_h;
   logic [4:0]            object_speed;
   logic [7:0]            object_destroy_time;
   logic [1:0]            object_destroy_trigger;
   // handoff handshake
   logic                  sync_object_position;
   logic                  update_object_position;
   // status
   logic                  busy;
   logic                  done;
   logic [7:0]            spawn_count;
   logic                  timeout_err;

   // sequencer side
   modport master (
      input  clk_centi_second, start, pause, rom_data, update_object_position,
      output rom_addr, object_movement_direction, object_pos_x, object_pos_y,
             object_w, object_h, object_speed, object_destroy_time,
             object_destroy_trigger, sync_object_position, busy, done,
             spawn_count, timeout_err
   );

   // environment side (ROM, consumer, controller)
   modport slave (
      output clk_centi_second, start, pause, rom_data, update_object_position,
      input  rom_addr, object_movement_direction, object_pos_x, object_pos_y,
             object_w, object_h, object_speed, object_destroy_time,
             object_destroy_trigger, sync_object_position, busy, done,
             spawn_count, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/object_spawn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : object_spawn_sequencer
// Description : Walks a pattern ROM of object descriptors, waits each entry's
//               spawn delay in centiseconds and hands the descriptor to the
//               collider runtime via the sync/update handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module object_spawn_sequencer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int LOOP_PATTERN = 0,
   parameter int START_ADDR   = 0,
   parameter int ACK_TIMEOUT  = 1023
) (
   input wire logic                   clk_calculation,
   input wire logic                   reset,
   object_spawn_sequencer_if.master   bus
);

   localparam int                    c_ACK_W     = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] c_START     = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [c_ACK_W-1:0]    c_ACK_LIMIT = c_ACK_W'(ACK_TIMEOUT);
   localparam logic [c_ACK_W-1:0]    c_ACK_ONE   = c_ACK_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_LATCH    = 3'd2,
      S_WAIT     = 3'd3,
      S_PRESENT  = 3'd4,
      S_ACK_WAIT = 3'd5,
      S_RELEASE  = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  r_tick_s1;
   logic                  r_tick_s2;
   logic                  r_tick_s3;
   logic                  w_tick;

   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [2:0]            r_dir;
   logic [9:0]            r_pos_x;
   logic [9:0]            r_pos_y;
   logic [9:0]            r_w;
   logic [9:0]            r_h;
   logic [4:0]            r_speed;
   logic [7:0]            r_destroy_time;
   logic [1:0]            r_destroy_trigger;
   logic [7:0]            r_wait_cnt;
   logic                  r_end;
   logic                  r_sync;
   logic [c_ACK_W-1:0]    r_ack_cnt;
   logic [7:0]            r_spawn_count;
   logic                  r_timeout_err;

   // control strobes from the next-state logic
   logic                  w_start_run;
   logic                  w_latch;
   logic                  w_wait_dec;
   logic                  w_present;
   logic                  w_ack_ok;
   logic                  w_ack_to;
   logic                  w_ack_inc;
   logic                  w_addr_incr;
   logic                  w_addr_restart;

   // one tick per rising edge of the synchronised centisecond clock
   assign w_tick = r_tick_s2 & ~r_tick_s3;

   // two-flop synchroniser plus edge-detect stage for the centisecond clock
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_tick_s1 <= 1'b0;
         r_tick_s2 <= 1'b0;
         r_tick_s3 <= 1'b0;
      end else begin
         r_tick_s1 <= bus.clk_centi_second;
         r_tick_s2 <= r_tick_s1;
         r_tick_s3 <= r_tick_s2;
      end
   end

   // state register
   always_ff @(posedge clk_calculation) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // next-state and strobe decode
   always_comb begin
      w_state_next   = r_state;
      w_start_run    = 1'b0;
      w_latch        = 1'b0;
      w_wait_dec     = 1'b0;
      w_present      = 1'b0;
      w_ack_ok       = 1'b0;
      w_ack_to       = 1'b0;
      w_ack_inc      = 1'b0;
      w_addr_incr    = 1'b0;
      w_addr_restart = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_start_run  = 1'b1;
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: w_state_next = S_LATCH;
         S_LATCH: begin
            w_latch      = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait_cnt == 8'd0)            w_state_next = S_PRESENT;
            else if (w_tick && !bus.pause)     w_wait_dec   = 1'b1;
         end
         S_PRESENT: begin
            w_present    = 1'b1;
            w_state_next = S_ACK_WAIT;
         end
         S_ACK_WAIT: begin
            if (bus.update_object_position) begin
               w_ack_ok     = 1'b1;
               w_state_next = S_RELEASE;
            end else if (r_ack_cnt == c_ACK_LIMIT) begin
               w_ack_to     = 1'b1;
               w_state_next = S_RELEASE;
            end else begin
               w_ack_inc    = 1'b1;
            end
         end
         S_RELEASE: begin
            // the consumer must drop its ack before the next entry is offered
            if (!bus.update_object_position) begin
               if (!r_end) begin
                  w_addr_incr  = 1'b1;
                  w_state_next = S_FETCH;
               end else if (LOOP_PATTERN != 0) begin
                  w_addr_restart = 1'b1;
                  w_state_next   = S_FETCH;
               end else begin
                  w_state_next = S_DONE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ROM address: restart on start/loop, natural wrap on increment
   always_ff @(posedge clk_calculation) begin
      if (reset)                             r_rom_addr <= c_START;
      else if (w_start_run || w_addr_restart) r_rom_addr <= c_START;
      else if (w_addr_incr)                  r_rom_addr <= r_rom_addr + c_ADDR_ONE;
   end

   // descriptor fields held from LATCH until the next LATCH
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_dir             <= 3'd0;
         r_pos_x           <= 10'd0;
         r_pos_y           <= 10'd0;
         r_w               <= 10'd0;
         r_h               <= 10'd0;
         r_speed           <= 5'd0;
         r_destroy_time    <= 8'd0;
         r_destroy_trigger <= 2'd0;
         r_end             <= 1'b0;
      end else if (w_latch) begin
         r_dir             <= bus.rom_data[58:56];
         r_pos_x           <= bus.rom_data[55:46];
         r_pos_y           <= bus.rom_data[45:36];
         r_w               <= bus.rom_data[35:26];
         r_h               <= bus.rom_data[25:16];
         r_speed           <= bus.rom_data[15:11];
         r_destroy_time    <= bus.rom_data[10:3];
         r_destroy_trigger <= bus.rom_data[2:1];
         r_end             <= bus.rom_data[0];
      end
   end

   // spawn delay countdown in centisecond ticks
   always_ff @(posedge clk_calculation) begin
      if (reset)           r_wait_cnt <= 8'd0;
      else if (w_latch)    r_wait_cnt <= bus.rom_data[66:59];
      else if (w_wait_dec) r_wait_cnt <= r_wait_cnt - 8'd1;
   end

   // handshake strobe (active low) and ack-timeout counter
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_sync    <= 1'b1;
         r_ack_cnt <= '0;
      end else begin
         if (w_present)                r_sync <= 1'b0;
         else if (w_ack_ok || w_ack_to) r_sync <= 1'b1;
         if (w_present)      r_ack_cnt <= '0;
         else if (w_ack_inc) r_ack_cnt <= r_ack_cnt + c_ACK_ONE;
      end
   end

   // acknowledged-spawn counter (saturating) and sticky timeout flag
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_spawn_count <= 8'd0;
         r_timeout_err <= 1'b0;
      end else if (w_start_run) begin
         r_spawn_count <= 8'd0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_ack_ok && (r_spawn_count != 8'hFF)) r_spawn_count <= r_spawn_count + 8'd1;
         if (w_ack_to)                             r_timeout_err <= 1'b1;
      end
   end

   assign bus.rom_addr                  = r_rom_addr;
   assign bus.object_movement_direction = r_dir;
   assign bus.object_pos_x              = r_pos_x;
   assign bus.object_pos_y              = r_pos_y;
   assign bus.object_w                  = r_w;
   assign bus.object_h                  = r_h;
   assign bus.object_speed              = r_speed;
   assign bus.object_destroy_time       = r_destroy_time;
   assign bus.object_destroy_trigger    = r_destroy_trigger;
   assign bus.sync_object_position      = r_sync;
   assign bus.busy                      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done                      = (r_state == S_DONE);
   assign bus.spawn_count               = r_spawn_count;
   assign bus.timeout_err               = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_object_spawn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_spawn_sequencer
// Description : Scoreboard bench for object_spawn_sequencer. Two instances:
//               A (linear pattern, short ack timeout) and B (4-entry ROM,
//               looping). Expected presentations come from a pattern-walk
//               model and are checked by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_spawn_sequencer;

   localparam int AW_A = 8;
   localparam int AW_B = 2;
   localparam int TO   = 8;

   typedef struct {
      int          addr;
      logic [57:0] fields;
   } exp_t;

   logic clk   = 1'b0;
   logic centi = 1'b0;
   logic rst_a;
   logic rst_b;

   int vectors    = 0;
   int miscompares = 0;

   exp_t exp_a[$];
   int   exp_b[$];

   logic [66:0] rom_a [256];
   logic [66:0] rom_b [4];

   // consumer A configuration
   logic ack_en_a  = 1'b1;
   int   ack_fixed = -1;

   object_spawn_sequencer_if #(.ADDR_WIDTH(AW_A)) bus_a ();
   object_spawn_sequencer_if #(.ADDR_WIDTH(AW_B)) bus_b ();

   always #5   clk   = ~clk;
   always #100 centi = ~centi;   // 20 clk cycles per centisecond tick

   assign bus_a.clk_centi_second = centi;
   assign bus_b.clk_centi_second = centi;

   object_spawn_sequencer #(
      .ADDR_WIDTH(AW_A), .LOOP_PATTERN(0), .START_ADDR(0), .ACK_TIMEOUT(TO)
   ) u_dut_a (
      .clk_calculation(clk), .reset(rst_a), .bus(bus_a)
   );

   object_spawn_sequencer #(
      .ADDR_WIDTH(AW_B), .LOOP_PATTERN(1), .START_ADDR(0), .ACK_TIMEOUT(TO)
   ) u_dut_b (
      .clk_calculation(clk), .reset(rst_b), .bus(bus_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [57:0] fields_a();
      return {bus_a.object_movement_direction, bus_a.object_pos_x, bus_a.object_pos_y,
              bus_a.object_w, bus_a.object_h, bus_a.object_speed,
              bus_a.object_destroy_time, bus_a.object_destroy_trigger};
   endfunction

   function automatic logic [66:0] rand_desc(input logic [7:0] wcs, input logic e);
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return {wcs, r[57:0], e};
   endfunction

   // Pattern-walk model for A: linear, stops at the first end-flagged entry
   task automatic model_a(input int start_addr, input int max_n);
      int a;
      a = start_addr;
      for (int n = 0; n < max_n; n++) begin
         exp_t e;
         e.addr   = a;
         e.fields = rom_a[a][58:1];
         exp_a.push_back(e);
         if (rom_a[a][0]) break;
         a = (a + 1) % 256;
      end
   endtask

   // Pattern-walk model for B: 4-entry ROM, end flag loops back to 0
   task automatic model_b(input int n_items);
      int a;
      a = 0;
      for (int n = 0; n < n_items; n++) begin
         exp_b.push_back(a);
         if (rom_b[a][0]) a = 0;
         else             a = (a + 1) % 4;
      end
   endtask

   // synchronous-read ROMs, data settles well before LATCH samples it
   always @(negedge clk) begin
      bus_a.rom_data = rom_a[bus_a.rom_addr];
      bus_b.rom_data = rom_b[bus_b.rom_addr];
   end

   // consumer A: acks after a configurable delay, releases after a random delay
   int ack_cnt_a = 0;
   int rel_cnt_a = 0;
   always @(negedge clk) begin
      if (rst_a) begin
         bus_a.update_object_position = 1'b0;
         ack_cnt_a = 0;
      end else if (bus_a.update_object_position) begin
         if (bus_a.sync_object_position) begin
            if (rel_cnt_a <= 0) bus_a.update_object_position = 1'b0;
            else                rel_cnt_a--;
         end
      end else if (!bus_a.sync_object_position) begin
         if (ack_en_a) begin
            if (ack_cnt_a <= 0) begin
               bus_a.update_object_position = 1'b1;
               rel_cnt_a = $urandom_range(0, 2);
            end else begin
               ack_cnt_a--;
            end
         end
      end else begin
         ack_cnt_a = (ack_fixed < 0) ? int'($urandom_range(0, 3)) : ack_fixed;
      end
   end

   // consumer B: immediate ack and release
   always @(negedge clk) begin
      bus_b.update_object_position = (rst_b === 1'b0) && (bus_b.sync_object_position === 1'b0);
   end

   // monitor A: pops the scoreboard on every presentation
   logic        prev_sync_a = 1'b1;
   logic [57:0] held_a      = '0;
   always @(posedge clk) begin
      #1;
      if (prev_sync_a === 1'b1 && bus_a.sync_object_position === 1'b0) begin
         if (exp_a.size() == 0) begin
            check("a_unexpected_present", 64'(bus_a.rom_addr), 64'hFFFF);
         end else begin
            exp_t e;
            e = exp_a.pop_front();
            check("a_present_addr", 64'(bus_a.rom_addr), 64'(e.addr));
            check("a_present_fields", 64'(fields_a()), 64'(e.fields));
            check("a_update_low_at_present", 64'(bus_a.update_object_position), 64'd0);
         end
         held_a = fields_a();
      end
      if (prev_sync_a === 1'b0 && bus_a.sync_object_position === 1'b1 && !rst_a)
         check("a_fields_held", 64'(fields_a()), 64'(held_a));
      prev_sync_a = bus_a.sync_object_position;
   end

   // monitor B: checks presentation order
   logic prev_sync_b = 1'b1;
   always @(posedge clk) begin
      #1;
      if (prev_sync_b === 1'b1 && bus_b.sync_object_position === 1'b0) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected_present", 64'(bus_b.rom_addr), 64'hFFFF);
         end else begin
            int ea;
            ea = exp_b.pop_front();
            check("b_present_addr", 64'(bus_b.rom_addr), 64'(ea));
            check("b_update_low_at_present", 64'(bus_b.update_object_position), 64'd0);
         end
      end
      prev_sync_b = bus_b.sync_object_position;
   end

   task automatic pulse_start_a();
      @(negedge clk); bus_a.start = 1'b1;
      @(negedge clk); bus_a.start = 1'b0;
   endtask

   task automatic pulse_start_b();
      @(negedge clk); bus_b.start = 1'b1;
      @(negedge clk); bus_b.start = 1'b0;
   endtask

   task automatic wait_sync_a(input logic lvl, input int budget, output int cycles);
      cycles = 0;
      while (bus_a.sync_object_position !== lvl && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= budget) check("a_sync_wait_timeout", 64'(cycles), 64'(budget - 1));
   endtask

   task automatic wait_done_a(input int budget);
      int c;
      c = 0;
      while (bus_a.done !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("a_done_reached", 64'(bus_a.done), 64'd1);
   endtask

   task automatic clear_rom_a();
      for (int i = 0; i < 256; i++) rom_a[i] = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int cyc;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.start = 1'b0; bus_a.pause = 1'b0;
      bus_b.start = 1'b0; bus_b.pause = 1'b0;
      clear_rom_a();
      for (int i = 0; i < 4; i++) rom_b[i] = '0;
      repeat (4) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      // T1: reset state
      check("rst_sync",        64'(bus_a.sync_object_position), 64'd1);
      check("rst_busy",        64'(bus_a.busy),        64'd0);
      check("rst_done",        64'(bus_a.done),        64'd0);
      check("rst_rom_addr",    64'(bus_a.rom_addr),    64'd0);
      check("rst_fields",      64'(fields_a()),        64'd0);
      check("rst_spawn_count", 64'(bus_a.spawn_count), 64'd0);
      check("rst_timeout_err", 64'(bus_a.timeout_err), 64'd0);

      // T2: single end-flagged entry, 3-tick delay, ack 2 cycles late
      rom_a[0] = {8'd3, 3'd5, 10'd100, 10'd50, 10'd40, 10'd8, 5'd7, 8'd20, 2'd1, 1'b1};
      ack_fixed = 2;
      model_a(0, 16);
      pulse_start_a();
      check("t2_busy", 64'(bus_a.busy), 64'd1);
      wait_sync_a(1'b0, 400, d);
      check("t2_delay_in_3tick_window", 64'((d >= 40) && (d <= 90)), 64'd1);
      wait_done_a(200);
      check("t2_spawn_count", 64'(bus_a.spawn_count), 64'd1);
      check("t2_busy_after",  64'(bus_a.busy),        64'd0);
      check("t2_pos_x",       64'(bus_a.object_pos_x), 64'd100);
      check("t2_pos_y",       64'(bus_a.object_pos_y), 64'd50);
      check("t2_w",           64'(bus_a.object_w),     64'd40);
      check("t2_h",           64'(bus_a.object_h),     64'd8);

      // T3: random back-to-back zero-delay entries, random ack/release timing
      clear_rom_a();
      for (int i = 0; i < 6; i++) rom_a[i] = rand_desc(8'd0, (i == 5));
      ack_fixed = -1;
      model_a(0, 16);
      pulse_start_a();
      wait_done_a(2000);
      check("t3_spawn_count", 64'(bus_a.spawn_count), 64'd6);
      check("t3_scoreboard_drained", 64'(exp_a.size()), 64'd0);

      // T4: pause held for 5 ticks during a 2-tick wait
      clear_rom_a();
      rom_a[0] = rand_desc(8'd2, 1'b1);
      ack_fixed = 0;
      model_a(0, 16);
      pulse_start_a();
      bus_a.pause = 1'b1;
      repeat (100) @(negedge clk);
      bus_a.pause = 1'b0;
      wait_sync_a(1'b0, 200, d);
      check("t4_paused_delay", 64'((100 + d >= 115) && (100 + d <= 175)), 64'd1);
      wait_done_a(200);
      check("t4_spawn_count", 64'(bus_a.spawn_count), 64'd1);

      // T5: entry 0 never acknowledged -> timeout, then entry 1 acked
      clear_rom_a();
      rom_a[0] = rand_desc(8'd0, 1'b0);
      rom_a[1] = rand_desc(8'd0, 1'b1);
      ack_en_a = 1'b0;
      model_a(0, 16);
      pulse_start_a();
      wait_sync_a(1'b0, 100, d);
      wait_sync_a(1'b1, 50, d);
      check("t5_timeout_len", 64'((d >= 8) && (d <= 10)), 64'd1);
      check("t5_timeout_err", 64'(bus_a.timeout_err), 64'd1);
      check("t5_count_unchanged", 64'(bus_a.spawn_count), 64'd0);
      ack_en_a = 1'b1;
      wait_done_a(200);
      check("t5_count_after_next", 64'(bus_a.spawn_count), 64'd1);
      check("t5_timeout_sticky",   64'(bus_a.timeout_err), 64'd1);

      // start clears timeout_err and spawn_count
      clear_rom_a();
      rom_a[0] = rand_desc(8'd1, 1'b1);
      model_a(0, 16);
      pulse_start_a();
      check("restart_timeout_cleared", 64'(bus_a.timeout_err), 64'd0);
      check("restart_count_cleared",   64'(bus_a.spawn_count), 64'd0);
      wait_done_a(200);
      check("restart_spawn_count", 64'(bus_a.spawn_count), 64'd1);

      // reset during a pending handshake
      clear_rom_a();
      rom_a[0] = rand_desc(8'd0, 1'b1);
      ack_en_a = 1'b0;
      model_a(0, 16);
      pulse_start_a();
      wait_sync_a(1'b0, 100, d);
      rst_a = 1'b1;
      @(negedge clk);
      check("midrst_sync",  64'(bus_a.sync_object_position), 64'd1);
      check("midrst_count", 64'(bus_a.spawn_count), 64'd0);
      check("midrst_busy",  64'(bus_a.busy), 64'd0);
      rst_a = 1'b0;
      ack_en_a = 1'b1;
      check("a_scoreboard_empty", 64'(exp_a.size()), 64'd0);

      // T6: looping instance, first with no end flag (wrap), then end at addr 2
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 4; i++) rom_b[i] = rand_desc(8'd0, (pass == 1) && (i == 2));
         model_b(5);
         pulse_start_b();
         cyc = 0;
         while (exp_b.size() != 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
         end
         check("t6_sequence_complete", 64'(exp_b.size()), 64'd0);
         check("t6_busy_looping", 64'(bus_b.busy), 64'd1);
         rst_b = 1'b1;
         repeat (2) @(negedge clk);
         check("t6_reset_addr", 64'(bus_b.rom_addr), 64'd0);
         rst_b = 1'b0;
         exp_b.delete();
         repeat (2) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
